// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - digit load / display drive bundle for seven_seg_scan_ctrl
//
// Purpose: groups the digit-load handshake and the registered display outputs.
// Signals:
//   digit_data  4*NUM_DIGITS  digit i = digit_data[4i+3:4i], digit 0 rightmost
//   load        1             one-cycle strobe, capture digit_data into staging
//   blank_mask  NUM_DIGITS    1 = keep that digit's anode off
//   dec_nibble  4             nibble to the shared decoder {z,y,x,w}
//   digit_en_n  NUM_DIGITS    active-low anode enables
//   frame_tick  1             one-cycle pulse at each frame boundary
//   update_ack  1             one-cycle pulse when staged data reaches the display
// master = data source / display observer, slave = scan controller.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              dec_nibble;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic                    frame_tick;
    logic                    update_ack;

    modport master (
        output digit_data, load, blank_mask,
        input  dec_nibble, digit_en_n, frame_tick, update_ack
    );

    modport slave (
        input  digit_data, load, blank_mask,
        output dec_nibble, digit_en_n, frame_tick, update_ack
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous double buffering
//
// Purpose: scans NUM_DIGITS common-anode digits through one shared hex decoder,
// with a blanking gap between digits and a staging/shadow pair so new codes only
// appear at a frame boundary.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    seven_seg_scan_if.slave (digit_data/load/blank_mask in;
//          dec_nibble/digit_en_n/frame_tick/update_ack out, all registered)
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    seven_seg_scan_if.slave   bus
);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int DW      = 4 * NUM_DIGITS;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         staging;
    logic [DW-1:0]         shadow;
    logic                  pending;
    logic [3:0]            dec_nibble_q;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic                  frame_tick_q;
    logic                  update_ack_q;

    logic                  blank_done;
    logic                  show_done;
    logic                  last_digit;
    logic [IW-1:0]         idx_inc;
    logic [NUM_DIGITS-1:0] idx_sel;
    logic [NUM_DIGITS-1:0] show_en_n;
    logic [3:0]            cur_nib;
    logic [3:0]            next_nib;

    assign blank_done = (cnt == CW'(BLANK_CYCLES - 1));
    assign show_done  = (cnt == CW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign idx_inc    = last_digit ? '0 : idx + 1'b1;
    assign idx_sel    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    // Anode pattern for the current digit; blank_mask is taken live so a mask
    // change lands on the very next edge.
    assign show_en_n  = ~(idx_sel & ~bus.blank_mask);
    assign cur_nib    = shadow[{idx, 2'b00} +: 4];
    assign next_nib   = shadow[{idx_inc, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= '0;
            staging      <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            dec_nibble_q <= 4'h0;
            digit_en_q   <= '1;
            frame_tick_q <= 1'b0;
            update_ack_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            update_ack_q <= 1'b0;

            if (bus.load) begin
                staging <= bus.digit_data;
                pending <= 1'b1;
            end

            case (state)
                ST_BLANK: begin
                    // Decoder input is already valid here so segments settle
                    // before the anode turns on.
                    dec_nibble_q <= cur_nib;
                    if (blank_done) begin
                        state      <= ST_SHOW;
                        cnt        <= '0;
                        digit_en_q <= show_en_n;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        digit_en_q <= '1;
                    end
                end
                ST_SHOW: begin
                    if (show_done) begin
                        state        <= ST_BLANK;
                        cnt          <= '0;
                        idx          <= idx_inc;
                        digit_en_q   <= '1;
                        dec_nibble_q <= next_nib;
                        if (last_digit) begin
                            frame_tick_q <= 1'b1;
                            // Shadow takes the staging value as it stood before
                            // this edge; a load on the same edge stays pending.
                            if (pending) begin
                                shadow       <= staging;
                                update_ack_q <= 1'b1;
                                dec_nibble_q <= staging[3:0];
                                if (!bus.load) begin
                                    pending <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        cnt          <= cnt + 1'b1;
                        digit_en_q   <= show_en_n;
                        dec_nibble_q <= cur_nib;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

    assign bus.dec_nibble = dec_nibble_q;
    assign bus.digit_en_n = digit_en_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.update_ack = update_ack_q;
endmodule
